// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Register file with scoreboard. It has DEPTH-1 writable N-bit
//            registers, where r0 is hard-wired to zero. It has two
//            combinational read ports with write bypass. Per-register busy
//            (pending-producer) bits are kept, and a single branch checkpoint
//            of the busy vector can be saved and restored.
// Ports    : clk, nreset         - clock, asynchronous active-low reset
//            we/waddr/wdata      - writeback port (also clears busy)
//            raddr1/2 -> rdata1/2, rbusy1/2 - combinational read ports
//            claim/claim_addr    - issue marks a destination busy
//            chk_save/chk_restore- snapshot / roll back the busy vector
//            nbusy               - registered popcount of busy bits
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter  int N     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2,
    output logic          rbusy1,
    output logic          rbusy2,
    input  logic          claim,
    input  logic [AW-1:0] claim_addr,
    input  logic          chk_save,
    input  logic          chk_restore,
    output logic [AW:0]   nbusy
);

    // Storage: entry 0 does not exist; bit 0 of busy/snap vectors is kept
    // permanently zero so they can be indexed directly by an address.
    logic [N-1:0]     mem_q  [DEPTH-1:1];
    logic [N-1:0]     mem_d  [DEPTH-1:1];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] snap_q, snap_d;
    logic [AW:0]      nbusy_q, nbusy_d;

    logic             wr_en;
    logic [DEPTH-1:0] wr_clr;
    logic [DEPTH-1:0] claim_set;
    logic [DEPTH-1:0] busy_upd;

    // Gating with nreset keeps the bypass from leaking wdata while in reset.
    assign wr_en = we & nreset & (waddr != '0);

    always_comb begin
        wr_clr    = '0;
        claim_set = '0;
        if (wr_en) begin
            wr_clr[waddr] = 1'b1;
        end
        if (claim && (claim_addr != '0)) begin
            claim_set[claim_addr] = 1'b1;
        end

        // Set after clear: a same-cycle claim names a newer producer.
        busy_upd = (busy_q & ~wr_clr) | claim_set;

        // Restore ignores claim and save, but still honours this cycle's write.
        if (chk_restore) begin
            busy_d = snap_q & ~wr_clr;
        end else begin
            busy_d = busy_upd;
        end

        // Writes also clear the snapshot so completed producers stay retired.
        if (chk_save && !chk_restore) begin
            snap_d = busy_upd;
        end else begin
            snap_d = snap_q & ~wr_clr;
        end

        nbusy_d = '0;
        for (int i = 1; i < DEPTH; i++) begin
            nbusy_d = nbusy_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    // Read ports: r0 is zero, then write bypass, then stored value.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (wr_en && (waddr == raddr1)) ? wdata : mem_q[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (wr_en && (waddr == raddr2)) ? wdata : mem_q[raddr2];
        end
        // busy_q[0] is always 0, so reads of r0 are never busy.
        rbusy1 = busy_q[raddr1] & ~(wr_en && (waddr == raddr1));
        rbusy2 = busy_q[raddr2] & ~(wr_en && (waddr == raddr2));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q  <= '0;
            snap_q  <= '0;
            nbusy_q <= '0;
        end else begin
            mem_q   <= mem_d;
            busy_q  <= busy_d;
            snap_q  <= snap_d;
            nbusy_q <= nbusy_d;
        end
    end

    assign nbusy = nbusy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb. It applies a table of
//            directed single-cycle vectors, followed by hand-written
//            checkpoint and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          nreset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic [AW-1:0] raddr1, raddr2;
    logic [N-1:0]  rdata1, rdata2;
    logic          rbusy1, rbusy2;
    logic          claim;
    logic [AW-1:0] claim_addr;
    logic          chk_save, chk_restore;
    logic [AW:0]   nbusy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    regfile_sb #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .nreset(nreset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2), .claim(claim), .claim_addr(claim_addr),
        .chk_save(chk_save), .chk_restore(chk_restore), .nbusy(nbusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [N-1:0]  wdata;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic          claim;
        logic [AW-1:0] caddr;
        logic [N-1:0]  e_rd1;
        logic [N-1:0]  e_rd2;
        logic          e_rb1;
        logic          e_rb2;
        logic [AW:0]   e_nb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; claim = 1'b0; claim_addr = '0;
        chk_save = 1'b0; chk_restore = 1'b0;
    endtask

    // Apply one cycle of control inputs starting at a negedge; return at the
    // following negedge with the inputs back at idle.
    task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                       input logic c, input logic [AW-1:0] ca,
                       input logic sv, input logic rs);
        we = w; waddr = wa; wdata = wd; claim = c; claim_addr = ca;
        chk_save = sv; chk_restore = rs;
        @(negedge clk);
        idle();
    endtask

    task automatic chk_busy(input string nm, input logic [AW-1:0] a, input logic exp);
        raddr1 = a;
        #1;
        chk(nm, {31'd0, rbusy1}, {31'd0, exp});
    endtask

    initial begin
        idle();
        raddr1 = '0; raddr2 = '0;
        nreset = 1'b0;

        // Table: checks taken mid-cycle before the edge that commits the row.
        vecs[0]  = '{1'b0, 4'd0, 8'h00, 4'd0, 4'd15, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b1, 4'd3, 8'hA5, 4'd3, 4'd0,  1'b0, 4'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[2]  = '{1'b1, 4'd0, 8'hFF, 4'd3, 4'd0,  1'b0, 4'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[3]  = '{1'b1, 4'd5, 8'h3C, 4'd5, 4'd5,  1'b0, 4'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 5'd0};
        vecs[4]  = '{1'b0, 4'd0, 8'h00, 4'd7, 4'd5,  1'b1, 4'd7, 8'h00, 8'h3C, 1'b0, 1'b0, 5'd0};
        vecs[5]  = '{1'b0, 4'd0, 8'h00, 4'd7, 4'd3,  1'b0, 4'd0, 8'h00, 8'hA5, 1'b1, 1'b0, 5'd1};
        vecs[6]  = '{1'b1, 4'd7, 8'h11, 4'd7, 4'd7,  1'b0, 4'd0, 8'h11, 8'h11, 1'b0, 1'b0, 5'd1};
        vecs[7]  = '{1'b0, 4'd0, 8'h00, 4'd7, 4'd0,  1'b0, 4'd0, 8'h11, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[8]  = '{1'b1, 4'd7, 8'h22, 4'd7, 4'd0,  1'b1, 4'd7, 8'h22, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[9]  = '{1'b0, 4'd0, 8'h00, 4'd7, 4'd0,  1'b0, 4'd0, 8'h22, 8'h00, 1'b1, 1'b0, 5'd1};
        vecs[10] = '{1'b1, 4'd7, 8'h33, 4'd7, 4'd0,  1'b0, 4'd0, 8'h33, 8'h00, 1'b0, 1'b0, 5'd1};
        vecs[11] = '{1'b0, 4'd0, 8'h00, 4'd7, 4'd0,  1'b0, 4'd0, 8'h33, 8'h00, 1'b0, 1'b0, 5'd0};

        // Reset state, then sweep every address.
        #2;
        chk("reset nbusy", {27'd0, nbusy}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            raddr1 = a[AW-1:0]; raddr2 = a[AW-1:0];
            #1;
            chk($sformatf("init r%0d data", a), {16'd0, rdata1, rdata2}, 32'd0);
            chk($sformatf("init r%0d busy", a), {30'd0, rbusy1, rbusy2}, 32'd0);
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
            claim = vecs[i].claim; claim_addr = vecs[i].caddr;
            chk_save = 1'b0; chk_restore = 1'b0;
            #2;
            chk($sformatf("v%0d rdata1", i), {24'd0, rdata1}, {24'd0, vecs[i].e_rd1});
            chk($sformatf("v%0d rdata2", i), {24'd0, rdata2}, {24'd0, vecs[i].e_rd2});
            chk($sformatf("v%0d rbusy1", i), {31'd0, rbusy1}, {31'd0, vecs[i].e_rb1});
            chk($sformatf("v%0d rbusy2", i), {31'd0, rbusy2}, {31'd0, vecs[i].e_rb2});
            chk($sformatf("v%0d nbusy", i),  {27'd0, nbusy},  {27'd0, vecs[i].e_nb});
        end

        // Checkpoint: claim r2; save+claim r4; claim r6; write r4; restore.
        @(negedge clk);
        idle();
        cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b0, 1'b0);
        chk("ckpt nbusy before write", {27'd0, nbusy}, 32'd3);
        cyc(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("ckpt nbusy before restore", {27'd0, nbusy}, 32'd2);
        cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("ckpt nbusy after restore", {27'd0, nbusy}, 32'd1);
        chk_busy("ckpt r2 busy", 4'd2, 1'b1);
        chk_busy("ckpt r4 busy", 4'd4, 1'b0);
        chk_busy("ckpt r6 busy", 4'd6, 1'b0);
        raddr1 = 4'd4;
        #1;
        chk("ckpt r4 data kept", {24'd0, rdata1}, 32'h44);

        // Restore with same-cycle write of r2 and an ignored claim of r10.
        @(negedge clk);
        cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b0, 1'b0);
        chk("ckpt2 nbusy pre", {27'd0, nbusy}, 32'd2);
        cyc(1'b1, 4'd2, 8'h22, 1'b1, 4'd10, 1'b1, 1'b1);
        chk("ckpt2 nbusy post", {27'd0, nbusy}, 32'd0);
        chk_busy("ckpt2 r9 busy", 4'd9, 1'b0);
        chk_busy("ckpt2 r10 busy", 4'd10, 1'b0);

        // Async reset mid-cycle after claiming r1..r5.
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 4'd0, 8'h00, 1'b1, k[AW-1:0], 1'b0, 1'b0);
        end
        chk("arst nbusy pre", {27'd0, nbusy}, 32'd5);
        we = 1'b1; waddr = 4'd3; wdata = 8'h77; claim = 1'b1; claim_addr = 4'd8;
        chk_save = 1'b1;
        raddr1 = 4'd3;
        #1;
        nreset = 1'b0;
        #1;
        chk("arst nbusy", {27'd0, nbusy}, 32'd0);
        chk("arst r3 data", {24'd0, rdata1}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            chk_busy($sformatf("arst r%0d busy", k), k[AW-1:0], 1'b0);
        end
        @(negedge clk);
        idle();
        nreset = 1'b1;
        cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("arst restore nbusy", {27'd0, nbusy}, 32'd0);
        chk_busy("arst restore r3 busy", 4'd3, 1'b0);
        chk_busy("arst restore r8 busy", 4'd8, 1'b0);
        raddr1 = 4'd3;
        #1;
        chk("arst r3 data after", {24'd0, rdata1}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
